instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum number of mem_ready-wait cycles before a bus error (range 1-255).
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port run, input, 1 bit: permits a new fetch when high.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory completion strobe for the current request.
REQ-006 SHALL have port mem_rdata, input, 32 bits: instruction word, valid when mem_ready=1 during a fetch.
REQ-007 SHALL have port mem_req, output, 1 bit: memory request, held until mem_ready or timeout.
REQ-008 SHALL have port mem_we, output, 1 bit: request is a store.
REQ-009 SHALL have port addr_sel, output, 1 bit: 0 = address from program counter, 1 = address from datapath mem_loca.
REQ-010 SHALL have port ir, output, 32 bits: latched instruction register, driving datapath decode fields.
REQ-011 SHALL have port pc_inc, output, 1 bit: datapath program-counter increment strobe.
REQ-012 SHALL have port ld, output, 1 bit: datapath load-data select.
REQ-013 SHALL have port write, output, 2 bits: datapath Y2/Y1 write enables.
REQ-014 SHALL have port halted, output, 1 bit: sequencer stopped in HALT or ERR.
REQ-015 SHALL have port bus_err, output, 1 bit: stopped on memory timeout.
REQ-016 SHALL have port retired, output, 16 bits: count of completed instructions.

Function
REQ-017 SHALL implement states IDLE, FETCH, EXEC, MEM, HALT, ERR, one-hot or encoded.
REQ-018 SHALL in IDLE drive all strobes low and go to FETCH when run=1, else remain in IDLE.
REQ-019 SHALL in FETCH assert mem_req=1, mem_we=0, addr_sel=0; on mem_ready=1 latch ir<=mem_rdata and go to EXEC the next cycle.
REQ-020 SHALL decode ir[31:30] in EXEC: 00 ALU, 01 load, 10 store, 11 halt.
REQ-021 SHALL for an ALU instruction drive, for exactly one EXEC cycle, write=ir[29:28] and pc_inc=1, increment retired, then go to IDLE.
REQ-022 SHALL for load/store go from EXEC to MEM with no strobes asserted in EXEC.
REQ-023 SHALL in MEM assert mem_req=1, addr_sel=1, and mem_we=1 for store only; mem_we SHALL be 0 for load.
REQ-024 SHALL on mem_ready in MEM for a load drive ld=1, write=2'b01, pc_inc=1 in that same cycle; for a store drive pc_inc=1, write=2'b00; in both cases increment retired and go to IDLE.
REQ-025 SHALL for halt drive pc_inc=1 in EXEC, increment retired, and enter HALT, which is left only by rst.
REQ-026 SHALL count consecutive mem_req cycles without mem_ready using an 8-bit wait counter; when the counter reaches TIMEOUT with mem_ready still 0, go to ERR with mem_req deasserted.
REQ-027 SHALL clear the wait counter on entry to FETCH and MEM.
REQ-028 SHALL treat mem_ready as taking priority over timeout in the same cycle.
REQ-029 SHALL hold bus_err=1 and halted=1 in ERR until rst.
REQ-030 SHALL hold halted=1 in HALT, with bus_err=0.
REQ-031 SHALL ignore mem_ready in IDLE, EXEC, HALT and ERR.
REQ-032 SHALL saturate retired at 16'hFFFF.
REQ-033 SHALL make run=0 affect only the IDLE->FETCH transition; an instruction in flight SHALL complete.
REQ-034 SHALL ensure pc_inc and any write bit are never high outside EXEC or the mem_ready cycle of MEM.
REQ-035 SHALL give a minimum instruction latency of 2 cycles for ALU and 3 cycles for load/store, with 1 IDLE cycle between instructions.

Reset
REQ-036 SHALL on rst=1 at a clock edge enter IDLE and clear ir=0, retired=0, wait counter=0, halted=0 and bus_err=0.
REQ-037 SHALL hold mem_req, mem_we, addr_sel, pc_inc, ld and write low while rst=1 and in the cycle after reset.
REQ-038 SHALL abandon any outstanding request when rst is asserted mid-FETCH or mid-MEM, with no pc_inc or write pulse.

Verification
REQ-039 SHALL check: run=1, mem_ready=1 immediately, fetch 32'h1000_0000 -> EXEC cycle with write=2'b01, pc_inc=1; retired=1.
REQ-040 SHALL check: load word 32'h4000_0000, MEM mem_ready delayed 3 cycles -> mem_req/addr_sel high for 4 cycles, mem_we=0, then ld=1, write=01, pc_inc=1 for 1 cycle.
REQ-041 SHALL check: store word 32'h8000_0000 -> MEM with mem_we=1; on mem_ready, pc_inc=1 and write=00.
REQ-042 SHALL check: TIMEOUT=4, mem_ready never asserted in FETCH -> bus_err=1 and halted=1 after 4 request cycles, mem_req=0 thereafter.
REQ-043 SHALL check: halt word 32'hC000_0000 -> halted=1, no further mem_req with run=1; rst -> halted=0, IDLE.
REQ-044 SHALL check: rst pulsed during MEM wait -> no pc_inc pulse, retired unchanged at 0, IDLE next cycle.

Source files
------------

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/execute/memory sequencer with bus timeout
module instr_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic [31:0] ir,
  output logic        pc_inc,
  output logic        ld,
  output logic [1:0]  write,
  output logic        halted,
  output logic        bus_err,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT,
    S_ERR
  } state_t;

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [15:0] retired_q, retired_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  wait_inc;
  logic        retire;
  logic        is_store;

  assign ir       = ir_q;
  assign retired  = retired_q;
  assign wait_inc = wait_q + 8'd1;
  assign is_store = ir_q[31];

  // Next-state, datapath strobes and wait-counter/retire bookkeeping
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    pc_inc    = 1'b0;
    ld        = 1'b0;
    write     = 2'b00;
    halted    = 1'b0;
    bus_err   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          wait_d  = 8'd0;
        end
      end
      S_FETCH: begin
        mem_req = 1'b1;
        // A completing memory beats a timeout landing in the same cycle
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = S_EXEC;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TIMEOUT_W) state_d = S_ERR;
        end
      end
      S_EXEC: begin
        case (ir_q[31:30])
          2'b00: begin
            write   = ir_q[29:28];
            pc_inc  = 1'b1;
            retire  = 1'b1;
            state_d = S_IDLE;
          end
          2'b11: begin
            pc_inc  = 1'b1;
            retire  = 1'b1;
            state_d = S_HALT;
          end
          default: begin
            wait_d  = 8'd0;
            state_d = S_MEM;
          end
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        if (mem_ready) begin
          pc_inc  = 1'b1;
          retire  = 1'b1;
          state_d = S_IDLE;
          if (!is_store) begin
            ld    = 1'b1;
            write = 2'b01;
          end
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TIMEOUT_W) state_d = S_ERR;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_ERR: begin
        halted  = 1'b1;
        bus_err = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    retired_d = (retire && (retired_q != 16'hFFFF)) ? retired_q + 16'd1 : retired_q;

    // Reset abandons any in-flight request without emitting datapath strobes
    if (rst) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      pc_inc   = 1'b0;
      ld       = 1'b0;
      write    = 2'b00;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ir_q      <= 32'd0;
      retired_q <= 16'd0;
      wait_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic [31:0] ir;
  logic        pc_inc;
  logic        ld;
  logic [1:0]  write;
  logic        halted;
  logic        bus_err;
  logic [15:0] retired;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  instr_sequencer #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir        (ir),
    .pc_inc    (pc_inc),
    .ld        (ld),
    .write     (write),
    .halted    (halted),
    .bus_err   (bus_err),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0;
    tick();
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_pc_inc", 32'(pc_inc), 0);
    chk("rst_write", 32'(write), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_mem_req", 32'(mem_req), 0);
    chk("post_rst_halted", 32'(halted), 0);
    chk("post_rst_bus_err", 32'(bus_err), 0);
    chk("post_rst_retired", 32'(retired), 0);
    chk("post_rst_ir", ir, 0);

    // reset pulsed while a load waits in MEM
    run = 1'b1;
    #1;
    chk("idle_mem_req", 32'(mem_req), 0);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h4000_0000; run = 1'b0;
    #1;
    chk("r44_fetch_req", 32'(mem_req), 1);
    tick();
    mem_ready = 1'b0;
    tick();
    #1;
    chk("r44_mem_req", 32'(mem_req), 1);
    chk("r44_mem_addr_sel", 32'(addr_sel), 1);
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    chk("r44_rst_pc_inc", 32'(pc_inc), 0);
    chk("r44_rst_write", 32'(write), 0);
    chk("r44_rst_mem_req", 32'(mem_req), 0);
    tick();
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    chk("r44_idle_mem_req", 32'(mem_req), 0);
    chk("r44_retired", 32'(retired), 0);
    chk("r44_pc_inc", 32'(pc_inc), 0);

    // ALU instruction, memory ready immediately
    run = 1'b1;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h1000_0000;
    #1;
    chk("alu_fetch_req", 32'(mem_req), 1);
    chk("alu_fetch_addr_sel", 32'(addr_sel), 0);
    chk("alu_fetch_we", 32'(mem_we), 0);
    chk("alu_fetch_pc_inc", 32'(pc_inc), 0);
    run = 1'b0;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("alu_ir", ir, 32'h1000_0000);
    chk("alu_write", 32'(write), 1);
    chk("alu_pc_inc", 32'(pc_inc), 1);
    chk("alu_exec_req", 32'(mem_req), 0);
    tick();
    #1;
    chk("alu_retired", 32'(retired), 1);
    chk("alu_idle_pc_inc", 32'(pc_inc), 0);
    chk("alu_idle_write", 32'(write), 0);

    // load with mem_ready delayed 3 cycles in MEM
    run = 1'b1;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h4000_0000; run = 1'b0;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("ld_exec_pc_inc", 32'(pc_inc), 0);
    chk("ld_exec_write", 32'(write), 0);
    chk("ld_exec_req", 32'(mem_req), 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ld_wait_req", 32'(mem_req), 1);
      chk("ld_wait_addr_sel", 32'(addr_sel), 1);
      chk("ld_wait_we", 32'(mem_we), 0);
      chk("ld_wait_ld", 32'(ld), 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("ld_rdy_req", 32'(mem_req), 1);
    chk("ld_rdy_we", 32'(mem_we), 0);
    chk("ld_rdy_ld", 32'(ld), 1);
    chk("ld_rdy_write", 32'(write), 1);
    chk("ld_rdy_pc_inc", 32'(pc_inc), 1);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("ld_done_ld", 32'(ld), 0);
    chk("ld_done_pc_inc", 32'(pc_inc), 0);
    chk("ld_done_req", 32'(mem_req), 0);
    chk("ld_retired", 32'(retired), 2);

    // store, memory ready on first MEM cycle
    run = 1'b1;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h8000_0000; run = 1'b0;
    tick();
    mem_ready = 1'b0;
    tick();
    mem_ready = 1'b1;
    #1;
    chk("st_req", 32'(mem_req), 1);
    chk("st_we", 32'(mem_we), 1);
    chk("st_addr_sel", 32'(addr_sel), 1);
    chk("st_pc_inc", 32'(pc_inc), 1);
    chk("st_write", 32'(write), 0);
    chk("st_ld", 32'(ld), 0);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("st_retired", 32'(retired), 3);
    chk("st_idle_we", 32'(mem_we), 0);

    // halt instruction, then recovery by reset
    run = 1'b1;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hC000_0000;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("halt_pc_inc", 32'(pc_inc), 1);
    chk("halt_write", 32'(write), 0);
    tick();
    #1;
    chk("halt_halted", 32'(halted), 1);
    chk("halt_bus_err", 32'(bus_err), 0);
    chk("halt_retired", 32'(retired), 4);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("halt_hold_req", 32'(mem_req), 0);
      chk("halt_hold_halted", 32'(halted), 1);
    end
    rst = 1'b1; run = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("halt_rst_halted", 32'(halted), 0);
    chk("halt_rst_retired", 32'(retired), 0);
    tick();
    #1;
    chk("halt_rst_idle_req", 32'(mem_req), 0);

    // fetch timeout with TIMEOUT=4
    run = 1'b1;
    tick();
    run = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_wait_req", 32'(mem_req), 1);
      tick();
    end
    #1;
    chk("to_err_req", 32'(mem_req), 0);
    chk("to_bus_err", 32'(bus_err), 1);
    chk("to_halted", 32'(halted), 1);
    mem_ready = 1'b1; run = 1'b1;
    tick();
    #1;
    chk("to_hold_bus_err", 32'(bus_err), 1);
    chk("to_hold_req", 32'(mem_req), 0);
    chk("to_hold_pc_inc", 32'(pc_inc), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
